// File: rtl/brisc_pkg.sv
// Shared core definitions: data/register widths, exception codes, and the
// multiplier tail depth that the hazard unit and the top level both use.
package brisc_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REGMSB = 4;   // register index is [REGMSB:0]

  localparam int unsigned MUL_TAIL_STAGES = 4;

  typedef enum logic [2:0] {
    NO_XCPT       = 3'd0,
    XCPT_ILLEGAL  = 3'd1,
    XCPT_MISALIGN = 3'd2,
    XCPT_OVERFLOW = 3'd3
  } xcpt_e;

  // One multiplier-tail stage payload.
  typedef struct packed {
    logic              valid;
    xcpt_e             xcpt;
    logic [REGMSB:0]   rd;
    logic [XLEN-1:0]   result;
  } mul_stage_t;

  localparam mul_stage_t STAGE_EMPTY = '{
    valid:  1'b0,
    xcpt:   NO_XCPT,
    rd:     '0,
    result: '0
  };

  // A stage will write the register file: valid, no exception, rd != x0.
  function automatic logic is_writer(input mul_stage_t st);
    return st.valid && (st.xcpt == NO_XCPT) && (st.rd != '0);
  endfunction

endpackage

// File: rtl/mul_tail_pipe_if.sv
// Multiplier tail bus: op entering from the first multiply stage, op leaving
// to writeback, and the decode-side scoreboard query/response.
//   master: upstream/decode side (drives *_in, observes *_out)
//   slave : mul_tail_pipe
interface mul_tail_pipe_if
  import brisc_pkg::*;
#(
  parameter int unsigned NSTAGES = MUL_TAIL_STAGES
) ();

  localparam int unsigned CNT_W = $clog2(NSTAGES + 1);

  logic              valid_in;
  xcpt_e             xcpt_in;
  logic [REGMSB:0]   rd_in;
  logic [XLEN-1:0]   result_in;
  logic [REGMSB:0]   rs1_q_in;
  logic [REGMSB:0]   rs2_q_in;

  logic              valid_out;
  xcpt_e             xcpt_out;
  logic [REGMSB:0]   rd_out;
  logic [XLEN-1:0]   result_out;
  logic              hazard1_out;
  logic              hazard2_out;
  logic [CNT_W-1:0]  inflight_out;

  modport master (
    output valid_in, xcpt_in, rd_in, result_in, rs1_q_in, rs2_q_in,
    input  valid_out, xcpt_out, rd_out, result_out,
           hazard1_out, hazard2_out, inflight_out
  );

  modport slave (
    input  valid_in, xcpt_in, rd_in, result_in, rs1_q_in, rs2_q_in,
    output valid_out, xcpt_out, rd_out, result_out,
           hazard1_out, hazard2_out, inflight_out
  );

endinterface

// File: rtl/mul_tail_reg.sv
// One multiplier-tail stage register. Priority: reset > flush > stall > load.
//   clk, reset : clock, synchronous active-high reset
//   flush      : clear the stage to an empty bubble
//   stall      : hold the current contents
//   d / q      : next / current stage payload
module mul_tail_reg
  import brisc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       stall,
  input  mul_stage_t d,
  output mul_stage_t q
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q <= STAGE_EMPTY;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mul_tail_pipe.sv
// Multiplier pipeline tail: carries the first-stage product through NSTAGES
// registers to writeback, and exposes a scoreboard view for decode hazards.
//   clk, reset : clock, synchronous active-high reset
//   stall_in   : freeze every stage
//   flush_in   : invalidate every stage (wins over stall_in)
//   bus        : op in, op out, rs1/rs2 hazard query and in-flight count
module mul_tail_pipe
  import brisc_pkg::*;
#(
  parameter int unsigned NSTAGES = MUL_TAIL_STAGES
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall_in,
  input  logic           flush_in,
  mul_tail_pipe_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(NSTAGES + 1);

  mul_stage_t d [NSTAGES];
  mul_stage_t s [NSTAGES];

  // Excepting ops carry a zero result; rd and valid pass unchanged.
  always_comb begin
    d[0].valid  = bus.valid_in;
    d[0].xcpt   = bus.xcpt_in;
    d[0].rd     = bus.rd_in;
    d[0].result = (bus.xcpt_in == NO_XCPT) ? bus.result_in : '0;
  end

  for (genvar i = 0; i < int'(NSTAGES); i++) begin : g_stage
    if (i > 0) begin : g_chain
      assign d[i] = s[i-1];
    end
    mul_tail_reg u_reg (
      .clk   (clk),
      .reset (reset),
      .flush (flush_in),
      .stall (stall_in),
      .d     (d[i]),
      .q     (s[i])
    );
  end

  assign bus.valid_out  = s[NSTAGES-1].valid;
  assign bus.xcpt_out   = s[NSTAGES-1].xcpt;
  assign bus.rd_out     = s[NSTAGES-1].rd;
  assign bus.result_out = s[NSTAGES-1].result;

  // Scoreboard match and valid popcount over all stages.
  logic             haz1;
  logic             haz2;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    cnt  = '0;
    for (int unsigned i = 0; i < NSTAGES; i++) begin
      if (is_writer(s[i]) && (s[i].rd == bus.rs1_q_in)) haz1 = 1'b1;
      if (is_writer(s[i]) && (s[i].rd == bus.rs2_q_in)) haz2 = 1'b1;
      cnt = cnt + CNT_W'(s[i].valid);
    end
  end

  assign bus.hazard1_out  = haz1;
  assign bus.hazard2_out  = haz2;
  assign bus.inflight_out = cnt;

endmodule

// File: tb/tb_mul_tail_pipe.sv
module tb_mul_tail_pipe;
  import brisc_pkg::*;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic reset, stall_in, flush_in;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  mul_tail_pipe_if #(.NSTAGES(N)) bus ();

  mul_tail_pipe #(.NSTAGES(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall_in (stall_in),
    .flush_in (flush_in),
    .bus      (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input xcpt_e x, input logic [REGMSB:0] rd,
                       input logic [XLEN-1:0] res);
    bus.valid_in  = v;
    bus.xcpt_in   = x;
    bus.rd_in     = rd;
    bus.result_in = res;
  endtask

  task automatic chk_out(input string tag, input logic v, input xcpt_e x,
                         input logic [REGMSB:0] rd, input logic [XLEN-1:0] res);
    chk({tag, ".valid"},  64'(bus.valid_out),  64'(v));
    chk({tag, ".xcpt"},   64'(bus.xcpt_out),   64'(x));
    chk({tag, ".rd"},     64'(bus.rd_out),     64'(rd));
    chk({tag, ".result"}, 64'(bus.result_out), 64'(res));
  endtask

  initial begin
    reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    drive(1'b0, NO_XCPT, '0, '0);
    bus.rs1_q_in = '0; bus.rs2_q_in = '0;

    // Reset state
    step(); step();
    chk_out("rst", 1'b0, NO_XCPT, 5'd0, 32'd0);
    chk("rst.haz1", 64'(bus.hazard1_out), 64'd0);
    chk("rst.haz2", 64'(bus.hazard2_out), 64'd0);
    chk("rst.inflight", 64'(bus.inflight_out), 64'd0);
    reset = 1'b0;
    step();

    // Single op: rd=5, 0x2A, visible exactly 4 edges later
    drive(1'b1, NO_XCPT, 5'd5, 32'h0000_002A);
    for (int i = 1; i <= 4; i++) begin
      step();
      drive(1'b0, NO_XCPT, '0, '0);
      chk("single.inflight", 64'(bus.inflight_out), 64'd1);
      if (i < 4) chk("single.early", 64'(bus.valid_out), 64'd0);
    end
    chk_out("single", 1'b1, NO_XCPT, 5'd5, 32'h2A);
    step();
    chk("single.drain.valid", 64'(bus.valid_out), 64'd0);
    chk("single.drain.inflight", 64'(bus.inflight_out), 64'd0);

    // Back-to-back rd 1..4, results 10..40
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, NO_XCPT, 5'(k), 32'(10 * k));
      step();
    end
    drive(1'b0, NO_XCPT, '0, '0);
    chk("b2b.inflight_full", 64'(bus.inflight_out), 64'd4);
    chk_out("b2b.op1", 1'b1, NO_XCPT, 5'd1, 32'd10);
    for (int j = 2; j <= 4; j++) begin
      step();
      chk_out("b2b.opn", 1'b1, NO_XCPT, 5'(j), 32'(10 * j));
      chk("b2b.inflight", 64'(bus.inflight_out), 64'(5 - j));
    end
    step();
    chk("b2b.drain", 64'(bus.valid_out), 64'd0);

    // Stall 3 cycles while op sits in s[1]; valid_in during stall is ignored
    drive(1'b1, NO_XCPT, 5'd7, 32'h77);
    step();
    drive(1'b0, NO_XCPT, '0, '0);
    step();
    stall_in = 1'b1;
    drive(1'b1, NO_XCPT, 5'd8, 32'h88);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.inflight", 64'(bus.inflight_out), 64'd1);
      chk("stall.valid", 64'(bus.valid_out), 64'd0);
    end
    stall_in = 1'b0;
    drive(1'b0, NO_XCPT, '0, '0);
    step();
    chk("stall.s2", 64'(bus.valid_out), 64'd0);
    step();
    chk_out("stall.out", 1'b1, NO_XCPT, 5'd7, 32'h77);
    step();
    chk("stall.nodup.valid", 64'(bus.valid_out), 64'd0);
    chk("stall.nodup.inflight", 64'(bus.inflight_out), 64'd0);

    // Flush with stall, 3 ops in flight; valid_in in flush cycle dropped
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, NO_XCPT, 5'(11 + k), 32'(100 + k));
      step();
    end
    chk("flush.pre_inflight", 64'(bus.inflight_out), 64'd3);
    flush_in = 1'b1; stall_in = 1'b1;
    drive(1'b1, NO_XCPT, 5'd14, 32'h14);
    bus.rs1_q_in = 5'd11;
    step();
    flush_in = 1'b0; stall_in = 1'b0;
    drive(1'b0, NO_XCPT, '0, '0);
    chk_out("flush", 1'b0, NO_XCPT, 5'd0, 32'd0);
    chk("flush.inflight", 64'(bus.inflight_out), 64'd0);
    chk("flush.haz1", 64'(bus.hazard1_out), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flush.lost", 64'(bus.valid_out), 64'd0);
    end
    bus.rs1_q_in = '0;

    // Hazard: rd=9 in flight
    drive(1'b1, NO_XCPT, 5'd9, 32'd1);
    step();
    drive(1'b0, NO_XCPT, '0, '0);
    bus.rs1_q_in = 5'd9; bus.rs2_q_in = 5'd3;
    #1;
    chk("haz.rs1_match", 64'(bus.hazard1_out), 64'd1);
    chk("haz.rs2_nomatch", 64'(bus.hazard2_out), 64'd0);
    bus.rs2_q_in = 5'd9;
    #1;
    chk("haz.rs2_match", 64'(bus.hazard2_out), 64'd1);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    chk("haz.after_flush", 64'(bus.hazard1_out), 64'd0);

    // rd=0 never a pending writer, query 0 never matches
    bus.rs1_q_in = '0; bus.rs2_q_in = '0;
    drive(1'b1, NO_XCPT, 5'd0, 32'd5);
    step();
    drive(1'b0, NO_XCPT, '0, '0);
    chk("haz.x0.h1", 64'(bus.hazard1_out), 64'd0);
    chk("haz.x0.h2", 64'(bus.hazard2_out), 64'd0);
    chk("haz.x0.inflight", 64'(bus.inflight_out), 64'd1);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;

    // Excepting op rd=9: not a writer, result zeroed, code passed through
    drive(1'b1, XCPT_ILLEGAL, 5'd9, 32'hFFFF_FFFF);
    step();
    drive(1'b0, NO_XCPT, '0, '0);
    bus.rs1_q_in = 5'd9;
    #1;
    chk("xcpt.haz1", 64'(bus.hazard1_out), 64'd0);
    step(); step(); step();
    chk_out("xcpt.out", 1'b1, XCPT_ILLEGAL, 5'd9, 32'd0);
    step();
    chk("xcpt.drain", 64'(bus.inflight_out), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Bound total simulation time.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
